dpram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one port of a DPRAM instance (synchronous, 1-cycle read latency, en/we/addr/din/dout per port) between NUM_REQ requesters.
- Each requester issues single-word read/write commands over a valid/ready handshake.
- Read data returns on a shared response bus tagged with the requester index.
- Sits between client engines and port A of the DPRAM; port B stays free for another agent.

---
 rtl/dpram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin arbiter sharing one DPRAM port between NUM_REQ requesters (optional locking via DPRAM_ARB_LOCK_EN)
module dpram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int IDW     = $clog2(NUM_REQ),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
`ifdef DPRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [AW-1:0]            ram_addr,
  output logic [WIDTH-1:0]         ram_din,
  input  logic [WIDTH-1:0]         ram_dout
);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant;
  logic               any_grant;
  logic               xfer;
  logic               adv;
  logic [NUM_REQ-1:0] eligible;
  logic [IDW-1:0]     next_ptr;

`ifdef DPRAM_ARB_LOCK_EN
  localparam logic ST_ARB    = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic           state;
  logic [IDW-1:0] lock_id;

  // While locked, only the lock owner is allowed to compete
  always_comb begin
    eligible = req_valid;
    if (state == ST_LOCKED) begin
      eligible          = '0;
      eligible[lock_id] = req_valid[lock_id];
    end
  end

  // The pointer stays put while a lock is being taken or held
  assign adv = xfer && !req_lock[grant];

  // ARB/LOCKED tracking; the entry transfer records the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ARB;
      lock_id <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (xfer && req_lock[grant]) begin
            state   <= ST_LOCKED;
            lock_id <= grant;
          end
        end
        default: begin
          if (xfer && !req_lock[lock_id]) begin
            state <= ST_ARB;
          end
        end
      endcase
    end
  end
`else
  assign eligible = req_valid;
  assign adv      = xfer;
`endif

  // Scan from rr_ptr upward with wrap; iterating downward lets the nearest slot win
  always_comb begin
    int             idx;
    logic [IDW-1:0] slot;
    any_grant = 1'b0;
    grant     = '0;
    idx       = 0;
    slot      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      slot = IDW'(idx);
      if (eligible[slot]) begin
        any_grant = 1'b1;
        grant     = slot;
      end
    end
  end

  // Nothing is accepted while reset is held
  assign xfer = any_grant && rst_n;

  // One-hot ready for the winning requester
  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Forward the granted command straight to the RAM port; idle drives zeros
  always_comb begin
    ram_en   = xfer;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (xfer) begin
      ram_we   = req_we[grant];
      ram_addr = req_addr[int'(grant)*AW +: AW];
      ram_din  = req_wdata[int'(grant)*WIDTH +: WIDTH];
    end
  end

  assign next_ptr  = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
  assign rsp_rdata = ram_dout;

  // Pointer rotation and one-cycle-delayed read response tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (adv) begin
        rr_ptr <= next_ptr;
      end
      rsp_valid <= xfer && !req_we[grant];
      if (xfer) begin
        rsp_id <= grant;
      end
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - directed table-driven bench for dpram_port_arbiter with a behavioural DPRAM
module tb_dpram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, req_we;
  logic [7:0]   req_addr;
  logic [127:0] req_wdata;
`ifdef DPRAM_ARB_LOCK_EN
  logic [3:0]   req_lock;
`endif
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_rdata;
  logic         ram_en, ram_we;
  logic [1:0]   ram_addr;
  logic [31:0]  ram_din;
  logic [31:0]  ram_dout;

  logic [31:0]  mem [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   we;
    logic [7:0]   addr;
    logic [127:0] wdata;
    logic [3:0]   ready;
    logic         en;
    logic         rwe;
    logic [1:0]   raddr;
    logic [31:0]  din;
    logic         rv;
    logic [1:0]   rid;
    logic [31:0]  rdata;
  } vec_t;

  localparam int NV = 23;
  vec_t v [NV];

  always #5 clk = ~clk;

  dpram_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DPRAM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Read-first synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] we, input logic [7:0] addr,
                              input logic [127:0] wdata, input logic [3:0] ready, input logic en,
                              input logic rwe, input logic [1:0] raddr, input logic [31:0] din,
                              input logic rv, input logic [1:0] rid, input logic [31:0] rdata);
    vec_t r;
    r.valid = valid; r.we = we; r.addr = addr; r.wdata = wdata;
    r.ready = ready; r.en = en; r.rwe = rwe; r.raddr = raddr; r.din = din;
    r.rv = rv; r.rid = rid; r.rdata = rdata;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] dval [4];
    dval[0] = 32'hA5A5A5A5; dval[1] = 32'h5A5A5A5A; dval[2] = 32'h10000002; dval[3] = 32'h10000003;
    for (int i = 0; i < 4; i++) mem[i] = 32'h10000000 + i;
    ram_dout = '0;

    // writes by 0 and 1, then two reads by 2
    v[0]  = mk(4'b0011, 4'b0011, 8'b00_00_01_00, {64'h0, 32'h5A5A5A5A, 32'hA5A5A5A5}, 4'b0001, 1, 1, 2'd0, 32'hA5A5A5A5, 0, 0, 0);
    v[1]  = mk(4'b0010, 4'b0010, 8'b00_00_01_00, {64'h0, 32'h5A5A5A5A, 32'hA5A5A5A5}, 4'b0010, 1, 1, 2'd1, 32'h5A5A5A5A, 0, 0, 0);
    v[2]  = mk(4'b0100, 4'b0000, 8'b00_00_00_00, 128'h0, 4'b0100, 1, 0, 2'd0, 0, 0, 0, 0);
    v[3]  = mk(4'b0100, 4'b0000, 8'b00_01_00_00, 128'h0, 4'b0100, 1, 0, 2'd1, 0, 1, 2'd2, 32'hA5A5A5A5);
    v[4]  = mk(4'b0000, 4'b0000, 8'b00_00_00_00, 128'h0, 4'b0000, 0, 0, 2'd0, 0, 1, 2'd2, 32'h5A5A5A5A);
    // requester 3 alone moves the pointer back to 0
    v[5]  = mk(4'b1000, 4'b0000, 8'b11_00_00_00, 128'h0, 4'b1000, 1, 0, 2'd3, 0, 0, 0, 0);
    // all four reading addr i: strict rotation
    for (int k = 0; k < 8; k++) begin
      v[6+k] = mk(4'b1111, 4'b0000, 8'b11_10_01_00, 128'h0, 4'(1 << (k % 4)), 1, 0, 2'(k % 4), 0,
                  1, 2'((k + 3) % 4), dval[(k + 3) % 4]);
    end
    v[14] = mk(4'b0000, 4'b0000, 8'b00_00_00_00, 128'h0, 4'b0000, 0, 0, 2'd0, 0, 1, 2'd3, 32'h10000003);
    // grant to 1, then 3 alone, then 0 and 3 together favour 0
    v[15] = mk(4'b0010, 4'b0000, 8'b00_00_01_00, 128'h0, 4'b0010, 1, 0, 2'd1, 0, 0, 0, 0);
    v[16] = mk(4'b1000, 4'b0000, 8'b11_00_00_00, 128'h0, 4'b1000, 1, 0, 2'd3, 0, 1, 2'd1, 32'h5A5A5A5A);
    v[17] = mk(4'b1001, 4'b0000, 8'b11_00_00_00, 128'h0, 4'b0001, 1, 0, 2'd0, 0, 1, 2'd3, 32'h10000003);
    v[18] = mk(4'b1000, 4'b0000, 8'b11_00_00_00, 128'h0, 4'b1000, 1, 0, 2'd3, 0, 1, 2'd0, 32'hA5A5A5A5);
    v[19] = mk(4'b0000, 4'b0000, 8'b00_00_00_00, 128'h0, 4'b0000, 0, 0, 2'd0, 0, 1, 2'd3, 32'h10000003);
    // write then immediate read of the same address by another requester
    v[20] = mk(4'b0001, 4'b0001, 8'b00_00_00_10, {96'h0, 32'h12345678}, 4'b0001, 1, 1, 2'd2, 32'h12345678, 0, 0, 0);
    v[21] = mk(4'b0010, 4'b0000, 8'b00_00_10_00, 128'h0, 4'b0010, 1, 0, 2'd2, 0, 0, 0, 0);
    v[22] = mk(4'b0000, 4'b0000, 8'b00_00_00_00, 128'h0, 4'b0000, 0, 0, 2'd0, 0, 1, 2'd1, 32'h12345678);

    rst_n = 1'b0; req_valid = 4'b1111; req_we = 4'b1111; req_addr = '0; req_wdata = '0;
`ifdef DPRAM_ARB_LOCK_EN
    req_lock = '0;
`endif
    #12;
    check("reset ready", req_ready, 4'b0000);
    check("reset ram_en", ram_en, 1'b0);
    check("reset ram_we", ram_we, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_id", rsp_id, 2'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0; req_we = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req_valid = v[i].valid; req_we = v[i].we; req_addr = v[i].addr; req_wdata = v[i].wdata;
      #1;
      check($sformatf("r%0d ready", i), req_ready, v[i].ready);
      check($sformatf("r%0d ram_en", i), ram_en, v[i].en);
      check($sformatf("r%0d ram_we", i), ram_we, v[i].rwe);
      check($sformatf("r%0d ram_addr", i), ram_addr, v[i].raddr);
      check($sformatf("r%0d ram_din", i), ram_din, v[i].din);
      check($sformatf("r%0d rsp_valid", i), rsp_valid, v[i].rv);
      if (v[i].rv) begin
        check($sformatf("r%0d rsp_id", i), rsp_id, v[i].rid);
        check($sformatf("r%0d rsp_rdata", i), rsp_rdata, v[i].rdata);
      end
    end

    // reset in the cycle after a read grant drops the response
    @(negedge clk);
    req_valid = 4'b0100; req_we = '0; req_addr = 8'b00_10_00_00; req_wdata = '0;
    #1 check("rst grant 2", req_ready, 4'b0100);
    @(negedge clk);
    check("pre-rst rsp_valid", rsp_valid, 1'b1);
    check("pre-rst rsp_rdata", rsp_rdata, 32'h12345678);
    rst_n = 1'b0; req_valid = 4'b0101;
    #1;
    check("mid-rst rsp_valid", rsp_valid, 1'b0);
    check("mid-rst ready", req_ready, 4'b0000);
    check("mid-rst ram_en", ram_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post-rst grant 0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0100;
    #1 check("post-rst grant 2", req_ready, 4'b0100);

`ifdef DPRAM_ARB_LOCK_EN
    @(negedge clk);
    req_valid = 4'b0001;
    #1 check("lock pre grant 0", req_ready, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 4'b0111; req_lock = (k < 2) ? 4'b0010 : 4'b0000;
      #1 check($sformatf("lock cycle %0d", k), req_ready, 4'b0010);
    end
    @(negedge clk);
    req_valid = 4'b0101; req_lock = '0;
    #1 check("lock release grant 2", req_ready, 4'b0100);
`endif

    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
